instr_fetch: RTL
================

# instr_fetch

Instruction fetch stage of the rv32 core. Holds the PC, issues word-aligned requests to instruction memory through a valid/ready port, and buffers in-order responses in a small FIFO. Delivers `{pc, instr, fault}` to decode/immediate generation through a valid/ready port. Accepts redirects (branch/jump targets computed downstream from the SB/UJ/I immediates) that flush all in-flight work.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: PC fetched first after reset.
- `FIFO_DEPTH`, 2: instruction buffer entries; power of two, ≥2.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `imem_req_valid` out 1: fetch request valid.
- `imem_req_ready` in 1: memory accepts request.
- `imem_req_addr` out 32: word-aligned fetch address.
- `imem_rsp_valid` in 1: response valid; responses return in request order, no backpressure.
- `imem_rsp_data` in 32: instruction word.
- `imem_rsp_err` in 1: access fault for this response.
- `redirect_valid` in 1: one-cycle redirect strobe.
- `redirect_pc` in 32: new PC.
- `out_valid` out 1: instruction available.
- `out_ready` in 1: decode accepts.
- `out_instr` out 32: instruction word.
- `out_pc` out 32: its PC.
- `out_fault` out 1: fetch fault marker.

## Operation
- States: FETCH, HALT. Reset enters FETCH.
- Credit rule in FETCH: `imem_req_valid` = `(outstanding + fifo_count) < FIFO_DEPTH`. Handshake increments `outstanding` and adds 4 to `fetch_pc` (wraps modulo 2^32).
- Each response decrements `outstanding`. If `drop_cnt` > 0, the response is discarded and `drop_cnt` decrements. Otherwise it is pushed as `{pc_tag, data, err}`, and `pc_tag` advances by 4.
- `imem_rsp_err`=1: entry pushed with `fault`=1 and `instr` = NOP (32'h0000_0013). State goes to HALT. No requests are issued in HALT.
- Redirect has priority over every other event in its cycle:
  - FIFO is flushed.
  - `drop_cnt` becomes all outstanding requests, including one accepted this cycle, minus any response arriving this cycle, which is itself dropped.
  - `fetch_pc` and `pc_tag` are loaded with `redirect_pc`.
  - State returns to FETCH.
- Misaligned redirect (`redirect_pc[1:0]` ≠ 0): no requests. After the drops, one entry `{redirect_pc, NOP, fault=1}` is pushed, then HALT.
- `out_*` handshake in a redirect cycle still counts as consumed.
- `imem_req_addr` is held stable while valid and not ready, except on redirect, where it may change.

## Timing
- Reset values: `imem_req_valid`=0, `imem_req_addr`=`RESET_PC`, `out_valid`=0, `out_instr`=0, `out_pc`=0, `out_fault`=0, counters=0.
- First request in the cycle after `rst_n` rises, address `RESET_PC`.
- Response in cycle N gives `out_valid` in cycle N+1 (registered FIFO head). No combinational path from `imem_rsp_*` to `out_*`.
- Redirect in cycle N gives a request to `redirect_pc` in cycle N+1 if credit allows.
- Full FIFO with `out_ready`=0: credit stops requests, so overflow never happens. Simultaneous push and pop on a full FIFO is legal.
- Reset mid-operation discards all state. Responses to pre-reset requests are not tracked.

## Configuration
- `IFETCH_PERF_EN` defined:
  - Adds outputs `perf_fetched` (32, counts `out` handshakes) and `perf_stall` (32, counts cycles with `out_ready`=1 and `out_valid`=0).
  - Both counters clear on reset and wrap.
- Undefined: these ports and counters do not exist.

## Structure
- `rv32_pkg` holds:
  - `RV32_NOP` = 32'h0000_0013.
  - `RV32_RESET_PC` default.
  - `fetch_entry_t` struct `{pc[31:0], instr[31:0], fault}`.
  - `fetch_state_t` enum `{FETCH, HALT}`.
- One sub-module, `fetch_fifo`:
  - Parameterised depth.
  - Push, pop and flush.
  - `count` output.
  - Registered head.

## Test plan
- Reset release, `imem_req_ready`=1, one-cycle memory → requests 0x0, 0x4, 0x8…. Outputs carry matching `out_pc` and are in order.
- `out_ready`=0 with depth 2 → at most 2 requests outstanding plus buffered. `imem_req_valid` drops. No lost or duplicated instruction after `out_ready` returns.
- Redirect to 0x100 with 2 requests outstanding → both responses dropped. Next output has `out_pc`=0x100.
- Redirect in the same cycle as a response and a request handshake → both dropped. Next delivered pc = redirect target.
- `imem_rsp_err` on pc 0x8 → output `{0x8, 0x00000013, fault=1}`, then no requests until a redirect to 0x40 resumes fetch.
- Redirect to 0x102 → single output `{0x102, NOP, fault=1}`, no memory request issued.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared rv32 front-end types and constants: fetch buffer entry, fetch FSM states, NOP encoding.
package rv32_pkg;

    localparam int unsigned XLEN          = 32;
    localparam logic [31:0] RV32_NOP      = 32'h0000_0013;
    localparam logic [31:0] RV32_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            fault;
    } fetch_entry_t;

    typedef enum logic {
        FETCH = 1'b0,
        HALT  = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Shift-register instruction buffer; entry 0 is the registered head seen by decode.
module fetch_fifo
    import rv32_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  fetch_entry_t  wdata,
    input  logic          pop,
    output fetch_entry_t  head,
    output logic          head_valid,
    output logic [CW-1:0] count
);

    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  mem_d [DEPTH];
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic [CW-1:0] cnt_pop;
    logic          valid_q;
    logic          pop_eff;
    logic          push_eff;

    // Pop shifts everything toward the head; push lands just past the surviving entries.
    always_comb begin
        mem_d    = mem_q;
        pop_eff  = pop && (count_q != '0);
        cnt_pop  = count_q - CW'(pop_eff);
        push_eff = push && (cnt_pop < CW'(DEPTH));
        count_d  = cnt_pop + CW'(push_eff);
        if (pop_eff) begin
            for (int i = 0; i < int'(DEPTH) - 1; i++) begin
                mem_d[i] = mem_q[i+1];
            end
        end
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (push_eff && (cnt_pop == CW'(i))) begin
                mem_d[i] = wdata;
            end
        end
        if (flush) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            count_q <= '0;
            valid_q <= 1'b0;
        end else begin
            mem_q   <= mem_d;
            count_q <= count_d;
            valid_q <= (count_d != '0);
        end
    end

    assign head       = mem_q[0];
    assign head_valid = valid_q;
    assign count      = count_q;

endmodule

// File: rtl/instr_fetch.sv
// rv32 instruction fetch: PC, credit-limited imem requests, in-order response buffer, redirect flush.
// Optional IFETCH_PERF_EN adds perf_fetched / perf_stall counters.
module instr_fetch
    import rv32_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RV32_RESET_PC,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        out_fault
`ifdef IFETCH_PERF_EN
   ,output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall
`endif
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned SW = CW + 1;

    fetch_state_t  state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   pc_tag_q, pc_tag_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] drop_q, drop_d;
    logic          pend_q, pend_d;
    logic          req_valid_q, req_valid_d;

    logic          req_hs;
    logic          rsp_hit;
    logic          out_pop;
    logic          fifo_flush;
    logic          fifo_push;
    fetch_entry_t  fifo_wdata;
    fetch_entry_t  fifo_head;
    logic          fifo_head_valid;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] cnt_d;

    assign req_hs  = req_valid_q && imem_req_ready;
    // Responses with nothing outstanding belong to requests issued before reset.
    assign rsp_hit = imem_rsp_valid && (outst_q != '0);
    assign out_pop = fifo_head_valid && out_ready;

    // Next-state: redirect wins over handshakes, responses and the pending misalignment fault.
    always_comb begin
        state_d          = state_q;
        fetch_pc_d       = fetch_pc_q;
        pc_tag_d         = pc_tag_q;
        outst_d          = outst_q + CW'(req_hs) - CW'(rsp_hit);
        drop_d           = drop_q;
        pend_d           = pend_q;
        fifo_flush       = 1'b0;
        fifo_push        = 1'b0;
        fifo_wdata.pc    = pc_tag_q;
        fifo_wdata.instr = imem_rsp_data;
        fifo_wdata.fault = 1'b0;
        if (redirect_valid) begin
            fifo_flush = 1'b1;
            drop_d     = outst_d;
            fetch_pc_d = redirect_pc;
            pc_tag_d   = redirect_pc;
            if (redirect_pc[1:0] != 2'b00) begin
                state_d = HALT;
                pend_d  = 1'b1;
            end else begin
                state_d = FETCH;
                pend_d  = 1'b0;
            end
        end else begin
            if (req_hs) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (rsp_hit) begin
                if (drop_q != '0) begin
                    drop_d = drop_q - CW'(1);
                end else begin
                    fifo_push = 1'b1;
                    pc_tag_d  = pc_tag_q + 32'd4;
                    if (imem_rsp_err) begin
                        fifo_wdata.instr = RV32_NOP;
                        fifo_wdata.fault = 1'b1;
                        state_d          = HALT;
                    end
                end
            end else if (pend_q && (drop_q == '0)) begin
                fifo_push        = 1'b1;
                fifo_wdata.instr = RV32_NOP;
                fifo_wdata.fault = 1'b1;
                pend_d           = 1'b0;
            end
        end
    end

    // Request valid is registered from next-cycle credit so it stays low through reset.
    assign cnt_d       = fifo_flush ? '0 : (fifo_count - CW'(out_pop) + CW'(fifo_push));
    assign req_valid_d = (state_d == FETCH) && ((SW'(outst_d) + SW'(cnt_d)) < SW'(FIFO_DEPTH));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= FETCH;
            fetch_pc_q  <= RESET_PC;
            pc_tag_q    <= RESET_PC;
            outst_q     <= '0;
            drop_q      <= '0;
            pend_q      <= 1'b0;
            req_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            pc_tag_q    <= pc_tag_d;
            outst_q     <= outst_d;
            drop_q      <= drop_d;
            pend_q      <= pend_d;
            req_valid_q <= req_valid_d;
        end
    end

    fetch_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (fifo_flush),
        .push      (fifo_push),
        .wdata     (fifo_wdata),
        .pop       (out_pop),
        .head      (fifo_head),
        .head_valid(fifo_head_valid),
        .count     (fifo_count)
    );

    assign imem_req_valid = req_valid_q;
    assign imem_req_addr  = fetch_pc_q;
    assign out_valid      = fifo_head_valid;
    assign out_instr      = fifo_head.instr;
    assign out_pc         = fifo_head.pc;
    assign out_fault      = fifo_head.fault;

`ifdef IFETCH_PERF_EN
    // Delivered instructions and decode-starved cycles; both wrap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else begin
            if (out_pop) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (out_ready && !fifo_head_valid) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule
